// File: rtl/branch_unit_bht_if.sv
// branch_unit_bht_if: EX resolve, IF lookup and result/perf bundle for branch_unit_bht
interface branch_unit_bht_if #(parameter int XLEN = 32, parameter int CNT_W = 32);
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic             ex_valid;
  logic             ex_stall;
  logic [XLEN-1:0]  ex_pc;
  logic [2:0]       ex_b_control;
  logic [XLEN-1:0]  ex_r1;
  logic [XLEN-1:0]  ex_r2;
  logic             ex_pred_taken;
  logic             res_valid;
  logic             branch_sel;
  logic             mispredict;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  modport master (
    output if_pc, ex_valid, ex_stall, ex_pc, ex_b_control, ex_r1, ex_r2, ex_pred_taken,
    input  if_pred_taken, res_valid, branch_sel, mispredict, branch_count, mispredict_count
  );
  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_pc, ex_b_control, ex_r1, ex_r2, ex_pred_taken,
    output if_pred_taken, res_valid, branch_sel, mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_unit_bht.sv
// branch_unit_bht: registered RV32I branch resolve with a 2-bit-counter BHT and mispredict/branch perf counters
module branch_unit_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst,
  branch_unit_bht_if.slave bus
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0]       r_bht [BHT_ENTRIES];
  logic             r_res_valid, r_branch_sel, r_mispredict;
  logic [CNT_W-1:0] r_branch_count, r_mispredict_count;
  logic [IW-1:0]    w_if_idx, w_ex_idx;
  logic [2:0]       w_c;
  logic [1:0]       w_ctr, w_ctr_nxt;
  logic             w_eq, w_lt, w_ltu, w_cond, w_cond_br, w_mis, w_unused;
  assign w_c       = bus.ex_b_control;
  assign w_if_idx  = bus.if_pc[IW+1:2];
  assign w_ex_idx  = bus.ex_pc[IW+1:2];
  assign w_eq      = bus.ex_r1 == bus.ex_r2;
  assign w_lt      = $signed(bus.ex_r1) < $signed(bus.ex_r2);
  assign w_ltu     = bus.ex_r1 < bus.ex_r2;
  assign w_cond    = w_c == 3'd1 ? w_eq :
                     w_c == 3'd2 ? !w_eq :
                     w_c == 3'd3 ? w_lt :
                     w_c == 3'd4 ? !w_lt :
                     w_c == 3'd5 ? w_ltu :
                     w_c == 3'd6 ? !w_ltu : w_c == 3'd7;
  assign w_cond_br = w_c != 3'd0 && w_c != 3'd7;
  assign w_mis     = w_c != 3'd0 && w_cond != bus.ex_pred_taken;
  assign w_ctr     = r_bht[w_ex_idx];
  assign w_ctr_nxt = w_cond ? (w_ctr == 2'b11 ? 2'b11 : w_ctr + 2'd1)
                            : (w_ctr == 2'b00 ? 2'b00 : w_ctr - 2'd1);
  assign w_unused  = &{1'b0, bus.if_pc, bus.ex_pc};
  // lookup reads the array before this edge's training write lands
  assign bus.if_pred_taken    = r_bht[w_if_idx][1];
  assign bus.res_valid        = r_res_valid;
  assign bus.branch_sel       = r_branch_sel;
  assign bus.mispredict       = r_mispredict;
  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
      r_res_valid        <= 1'b0;
      r_branch_sel       <= 1'b0;
      r_mispredict       <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (!bus.ex_stall) begin
      r_res_valid  <= bus.ex_valid;
      r_branch_sel <= bus.ex_valid && w_cond;
      r_mispredict <= bus.ex_valid && w_mis;
      if (bus.ex_valid && w_cond_br) begin
        r_bht[w_ex_idx] <= w_ctr_nxt;
        r_branch_count  <= r_branch_count + CNT_W'(1);
        if (w_mis) r_mispredict_count <= r_mispredict_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/branch_unit_bht.md
Name: branch_unit_bht

Overview:
- Parametrised successor to the combinational branch comparator. It resolves RV32I branch conditions for any XLEN and registers the result with a fixed 1-cycle latency.
- Adds a PC-indexed branch history table (BHT) of 2-bit saturating counters. The table gives fetch-stage taken/not-taken predictions and is trained on every resolved branch.
- Flags mispredicts against the prediction carried down the pipe, and keeps branch and mispredict performance counters.
- Sits between the EX stage (resolve) and the IF stage (prediction lookup).

Parameters:
- XLEN, 32, operand and PC width.
- BHT_ENTRIES, 64, number of BHT entries; must be a power of 2, ≥ 2.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_pc  in  XLEN  fetch PC used for prediction lookup
- if_pred_taken  out  1  prediction for if_pc (combinational)
- ex_valid  in  1  a branch/jump is present in EX this cycle
- ex_stall  in  1  EX is stalled; the resolve inputs are ignored
- ex_pc  in  XLEN  PC of the EX instruction
- ex_b_control  in  3  condition select (encoding below)
- ex_r1  in  XLEN  rs1 operand
- ex_r2  in  XLEN  rs2 operand
- ex_pred_taken  in  1  prediction made for this instruction at fetch
- res_valid  out  1  registered: branch_sel and mispredict are valid
- branch_sel  out  1  registered: branch taken
- mispredict  out  1  registered: branch_sel differs from ex_pred_taken
- branch_count  out  CNT_W  resolved conditional branches
- mispredict_count  out  CNT_W  mispredicted conditional branches

Behaviour:
- ex_b_control encoding:
  - 000: none
  - 001: BEQ
  - 010: BNE
  - 011: BLT (signed)
  - 100: BGE (signed)
  - 101: BLTU
  - 110: BGEU
  - 111: JAL/JALR (always taken)
- Compares use the full XLEN bits. Signed compares treat bit XLEN-1 as the sign bit.
- Index function: idx = pc[$clog2(BHT_ENTRIES)+1 : 2]. PC bits [1:0] are ignored.
- Prediction: if_pred_taken = BHT[idx(if_pc)][1]. It is purely combinational and has no stall gating.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Counter update: a taken branch increments the counter, saturating at 11; a not-taken branch decrements it, saturating at 00.
- Accepted resolve: a cycle with ex_valid=1, ex_stall=0 and rst=0.
  - Edge N: res_valid←1, branch_sel←cond, mispredict←(cond≠ex_pred_taken). The outputs are visible in cycle N+1.
  - The BHT is trained at the same edge, only for codes 001–110.
  - Code 111 gives branch_sel=1 and mispredict=~ex_pred_taken. It does not update the BHT or any counter.
  - Code 000 gives branch_sel=0 and mispredict=0. It does not update the BHT or any counter.
- Cycle with ex_valid=0 and ex_stall=0: res_valid←0; branch_sel and mispredict←0.
- Cycle with ex_stall=1: all registered outputs, the BHT and the counters hold their values regardless of ex_valid.
- Performance counters count only codes 001–110.
  - branch_count increments by 1 per accepted resolve.
  - mispredict_count increments by 1 when mispredict is set.
  - Both wrap modulo 2^CNT_W.
- Simultaneous lookup and update of the same index: if_pred_taken shows the pre-update value (read-before-write). The new value is visible from the next cycle.
- Reset:
  - At the edge where rst=1: every BHT entry←01, res_valid, branch_sel and mispredict←0, both counters←0.
  - rst has priority over ex_valid and ex_stall.
  - A resolve in flight during reset is discarded.
  - if_pred_taken reads 0 from the cycle after reset.

Test Plan:
- Reset, then BEQ with r1=r2=32'hF0000000, pred=0 → next cycle: res_valid=1, branch_sel=1, mispredict=1, branch_count=1, mispredict_count=1; BHT[idx] now 10, so if_pred_taken=1 for that pc.
- Signed vs unsigned with r1=32'hF0000001, r2=32'h00000001: BLT → taken; BLTU → not taken; BGE → not taken; BGEU → taken. Each result appears exactly 1 cycle after its input.
- Saturation at pc=0x100: 4 consecutive taken BEQs take the counter 01→10→11→11. Then one not-taken BNE (r1=r2) → 10, with if_pred_taken still 1. A second not-taken → 01, with if_pred_taken=0.
- Aliasing and same-cycle read/write: pc 0x100 and 0x200 share an index (BHT_ENTRIES=64). Update via 0x200 while if_pc=0x100 in the same cycle → old value that cycle, new value the next.
- Stall/JAL/none: ex_stall=1 with ex_valid=1 → outputs, counters and BHT frozen. JAL with pred=0 → branch_sel=1, mispredict=1, counters unchanged. Code 000 → branch_sel=0, no counter change.
- Reset mid-operation: assert rst in the same cycle as a valid BEQ → next cycle res_valid=0, counters=0, all BHT entries=01; the pending branch is never reported.
